dmem_responder: RTL and testbench

Data-memory responder serving the single-cycle MIPS datapath's data port. It accepts the datapath's load/store request (address, store data, read/write strobes) and holds the datapath via a stall line while it models a fixed-latency word-addressed RAM. On completion it returns load data, or commits store data, with a one-cycle ready pulse. It sits between the datapath's data-memory outputs and its memory read-data input, alongside the controller, which gates the PC with `memStall`.

---
 rtl/dmem_responder.sv | 73 +++++++
 tb/tb_dmem_responder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word-addressed data RAM that stalls the datapath until each access completes.
// Optional DMEM_ALIGN_CHECK_EN flags accepted requests with memAddress[1:0] != 0 as errors.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] memAddress,
   input  logic [31:0] memWriteData,
   input  logic        memRead,
   input  logic        memWrite,
   output logic [31:0] memReadData,
   output logic        memReady,
   output logic        memStall,
   output logic        memError
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
   logic [1:0] state, nextState;
   logic [3:0] count;
   logic [AW-1:0] addrQ, idx;
   logic [31:0] dataQ, wData;
   logic writeQ, errQ, isWrite, isErr, idle, req, badReq, commit, unusedAddr;
   logic [31:0] mem [DEPTH_WORDS];
   assign req = memRead | memWrite;
`ifdef DMEM_ALIGN_CHECK_EN
   assign badReq = (memRead & memWrite) | (memAddress[1:0] != 2'b00);
   assign unusedAddr = ^memAddress[31:AW+2];
`else
   assign badReq = memRead & memWrite;
   assign unusedAddr = ^{memAddress[31:AW+2], memAddress[1:0]};
`endif
   assign memStall = req & (state != DONE);
   assign idle = state == IDLE;
   // With zero latency the access completes on the accept edge, so use live inputs in IDLE.
   assign idx = idle ? memAddress[AW+1:2] : addrQ;
   assign wData = idle ? memWriteData : dataQ;
   assign isWrite = idle ? memWrite : writeQ;
   assign isErr = idle ? badReq : errQ;
   assign commit = (nextState == DONE) & ~rst;
   always_comb begin
      nextState = idle ? (req ? ((LATENCY == 0) ? DONE : BUSY) : IDLE)
                : (state == BUSY) ? ((count == 4'd1) ? DONE : BUSY)
                : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= 4'd0;
         memReadData <= 32'd0;
         memReady <= 1'b0;
         memError <= 1'b0;
      end else begin
         state <= nextState;
         memReady <= nextState == DONE;
         if (idle && req) begin
            addrQ <= memAddress[AW+1:2];
            dataQ <= memWriteData;
            writeQ <= memWrite;
            errQ <= badReq;
            count <= 4'(LATENCY);
            memError <= memError | badReq;
         end else if (state == BUSY) begin
            count <= count - 4'd1;
         end
         if (commit && !isErr && !isWrite) memReadData <= mem[idx];
      end
   end
   always_ff @(posedge clk) begin
      if (commit && isWrite && !isErr) mem[idx] <= wData;
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder at LATENCY 2 plus a LATENCY 0 instance.
module tb_dmem_responder;
   localparam int LAT = 2;
   typedef struct packed {logic [31:0] data; logic err;} expT;
   logic clk = 1'b0, rst = 1'b1;
   logic memRead = 1'b0, memWrite = 1'b0;
   logic [31:0] memAddress = 32'd0, memWriteData = 32'd0;
   logic [31:0] memReadData;
   logic memReady, memStall, memError;
   logic zRead = 1'b0, zWrite = 1'b0;
   logic [31:0] zAddress = 32'd0, zWriteData = 32'd0, zReadData;
   logic zReady, zStall, zError;
   logic [31:0] model [1024];
   logic [31:0] lastRead = 32'd0;
   logic errSticky = 1'b0, prevReady = 1'b0;
   expT expQ[$];
   expT monExp;
   int nTests = 0, nFail = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .memAddress(memAddress), .memWriteData(memWriteData),
      .memRead(memRead), .memWrite(memWrite), .memReadData(memReadData),
      .memReady(memReady), .memStall(memStall), .memError(memError));

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dutZ (
      .clk(clk), .rst(rst), .memAddress(zAddress), .memWriteData(zWriteData),
      .memRead(zRead), .memWrite(zWrite), .memReadData(zReadData),
      .memReady(zReady), .memStall(zStall), .memError(zError));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (memReady) begin
         check("readyPulse", 32'(prevReady), 32'd0);
         if (expQ.size() == 0) check("unexpectedReady", 32'd1, 32'd0);
         else begin
            monExp = expQ.pop_front();
            check("readData", memReadData, monExp.data);
            check("error", 32'(memError), 32'(monExp.err));
         end
      end
      prevReady <= memReady;
   end

   task automatic doReq(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
      int idx, waits, stalls;
      logic err, seen;
      idx = int'(addr[11:2]);
      err = rd & wr;
`ifdef DMEM_ALIGN_CHECK_EN
      err = err | (addr[1:0] != 2'b00);
`endif
      if (!err && wr) model[idx] = data;
      if (!err && rd) lastRead = model[idx];
      errSticky = errSticky | err;
      expQ.push_back(expT'{data: lastRead, err: errSticky});
      memRead = rd;
      memWrite = wr;
      memAddress = addr;
      memWriteData = data;
      waits = 0;
      stalls = 0;
      seen = 1'b0;
      while (!seen && waits < 40) begin
         @(negedge clk);
         waits++;
         if (memStall) stalls++;
         seen = memReady;
      end
      check("timeout", 32'(seen), 32'd1);
      check("latency", waits, LAT + 2);
      check("stallCycles", stalls, LAT + 1);
      @(posedge clk);
      #1;
      memRead = 1'b0;
      memWrite = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         model[i] = 32'hC0DE0000 ^ 32'(i);
         dut.mem[i] = model[i];
         dutZ.mem[i] = model[i];
      end
      dutZ.mem[5] = 32'h12345678;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rstReadData", memReadData, 32'd0);
      check("rstReady", 32'(memReady), 32'd0);
      check("rstError", 32'(memError), 32'd0);
      check("rstStallIdle", 32'(memStall), 32'd0);
      memRead = 1'b1;
      #1;
      check("rstStallReq", 32'(memStall), 32'd1);
      @(posedge clk);
      #1;
      memRead = 1'b0;
      rst = 1'b0;
      doReq(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      doReq(1'b1, 1'b0, 32'h10, 32'd0);
      doReq(1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5);
      doReq(1'b1, 1'b0, 32'h0, 32'd0);
      doReq(1'b0, 1'b1, 32'hFFC, 32'h0BADCAFE);
      doReq(1'b1, 1'b0, 32'hFFC, 32'd0);
      doReq(1'b1, 1'b0, 32'h13, 32'd0);
      doReq(1'b1, 1'b1, 32'h40, 32'h77777777);
      doReq(1'b1, 1'b0, 32'h40, 32'd0);
      doReq(1'b1, 1'b0, 32'h10, 32'd0);
      memWrite = 1'b1;
      memAddress = 32'h20;
      memWriteData = 32'h11111111;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("midRstReady", 32'(memReady), 32'd0);
      @(posedge clk);
      #1;
      memWrite = 1'b0;
      @(negedge clk);
      check("midRstReadData", memReadData, 32'd0);
      check("midRstReady2", 32'(memReady), 32'd0);
      check("midRstError", 32'(memError), 32'd0);
      check("midRstStall", 32'(memStall), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      expQ.delete();
      lastRead = 32'd0;
      errSticky = 1'b0;
      doReq(1'b1, 1'b0, 32'h20, 32'd0);
      zRead = 1'b1;
      zAddress = 32'h14;
      @(negedge clk);
      check("zStallIdle", 32'(zStall), 32'd1);
      check("zReadyIdle", 32'(zReady), 32'd0);
      @(negedge clk);
      check("zReady", 32'(zReady), 32'd1);
      check("zStallDone", 32'(zStall), 32'd0);
      check("zReadData", zReadData, 32'h12345678);
      check("zError", 32'(zError), 32'd0);
      @(posedge clk);
      #1;
      zRead = 1'b0;
      @(negedge clk);
      check("zReadyDrop", 32'(zReady), 32'd0);
      check("queueEmpty", 32'(expQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
